instruction_decode: RTL

Decode stage of the RISC-Net pipeline, directly downstream of instruction fetch. It accepts one 32-bit instruction per cycle from fetch, splits it into fields, reads and bypasses source operands from the register file, and stalls on register hazards using a 16-entry busy scoreboard. Decoded operations go to execute through a single registered valid/ready slot.

---
 rtl/risc_pkg.sv | 83 ++++++++
 rtl/decode_scoreboard.sv | 60 ++++++
 rtl/instruction_decode.sv | 127 ++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared RISC-Net decode constants, field layout and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 16;
    localparam int REG_W = 4;
    localparam int OP_W  = 6;
    localparam int IMM_W = 14;

    localparam int OPC_LSB = 26;
    localparam int RD_LSB  = 22;
    localparam int RS1_LSB = 18;
    localparam int RS2_LSB = 14;
    localparam int IMM_LSB = 0;
    localparam int FN_LSB  = 0;
    localparam int FN_W    = 4;

    localparam logic [OP_W-1:0] OP_ALU   = 6'h00;
    localparam logic [OP_W-1:0] OP_ALUI  = 6'h01;
    localparam logic [OP_W-1:0] OP_LOAD  = 6'h02;
    localparam logic [OP_W-1:0] OP_STORE = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h05;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic writes_rd;
        logic illegal;
    } op_ctrl_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [FN_W-1:0]  funct;
        logic [REG_W-1:0] rd;
        logic             wen;
        logic             illegal;
        logic [XLEN-1:0]  rs1_val;
        logic [XLEN-1:0]  rs2_val;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } slot_t;

    function automatic op_ctrl_t op_decode(input logic [OP_W-1:0] op);
        op_ctrl_t c;
        c = '0;
        case (op)
            OP_ALU:   begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.writes_rd = 1'b1; end
            OP_ALUI,
            OP_LOAD:  begin c.use_rs1 = 1'b1; c.writes_rd = 1'b1; end
            OP_STORE,
            OP_BEQ:   begin c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; end
            OP_JAL:   c.writes_rd = 1'b1;
            default:  c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    // r0 reads zero; a same-cycle writeback beats the stale register file value.
    function automatic logic [XLEN-1:0] operand_sel(
        input logic             used,
        input logic [REG_W-1:0] src,
        input logic [XLEN-1:0]  rf_data,
        input logic             wb_valid,
        input logic [REG_W-1:0] wb_rd,
        input logic [XLEN-1:0]  wb_data
    );
        logic [XLEN-1:0] v;
        v = '0;
        if (used && (src != '0)) begin
            if (wb_valid && (wb_rd == src)) v = wb_data;
            else                            v = rf_data;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : decode_scoreboard
// Description : Register busy vector with set/clear/flush priority and hazard query.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard
    import risc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             use_rs1_i,
    input  logic             use_rs2_i,
    input  logic             wen_i,
    input  logic             accept_i,
    input  logic             wb_valid_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             flush_clr_i,
    input  logic [REG_W-1:0] flush_rd_i,
    output logic             hazard_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] wb_clr_w;
    logic [NREG-1:0] fl_clr_w;
    logic [NREG-1:0] set_w;
    logic            raw1_w;
    logic            raw2_w;
    logic            waw_w;

    always_comb begin
        wb_clr_w = '0;
        fl_clr_w = '0;
        set_w    = '0;
        if (wb_valid_i)          wb_clr_w[wb_rd_i]   = 1'b1;
        if (flush_clr_i)         fl_clr_w[flush_rd_i] = 1'b1;
        if (accept_i && wen_i)   set_w[rd_i]         = 1'b1;
        // Set is applied last so it wins over any clear of the same bit.
        busy_d    = (busy_q & ~wb_clr_w & ~fl_clr_w) | set_w;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        raw1_w   = use_rs1_i && busy_q[rs1_i] && !wb_clr_w[rs1_i];
        raw2_w   = use_rs2_i && busy_q[rs2_i] && !wb_clr_w[rs2_i];
        waw_w    = wen_i     && busy_q[rd_i]  && !wb_clr_w[rd_i];
        hazard_o = raw1_w || raw2_w || waw_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
// Module      : instruction_decode
// Description : RISC-Net decode stage: field split, operand bypass, hazard stall, output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode
    import risc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic [REG_W-1:0] rf_rs1_addr,
    output logic [REG_W-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_data,
    input  logic [XLEN-1:0]  rf_rs2_data,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [OP_W-1:0]  ex_op,
    output logic [FN_W-1:0]  ex_funct,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_wen,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic             ex_illegal
);

    logic [OP_W-1:0]  op_w;
    logic [REG_W-1:0] rd_w;
    logic [REG_W-1:0] rs1_w;
    logic [REG_W-1:0] rs2_w;
    op_ctrl_t         ctrl_w;
    logic             wen_w;
    logic             hazard_w;
    logic             accept_w;
    logic             flush_clr_w;

    logic             ex_valid_q;
    logic             ex_valid_d;
    slot_t            slot_q;
    slot_t            slot_d;

    assign op_w   = if_instr[OPC_LSB +: OP_W];
    assign rd_w   = if_instr[RD_LSB  +: REG_W];
    assign rs1_w  = if_instr[RS1_LSB +: REG_W];
    assign rs2_w  = if_instr[RS2_LSB +: REG_W];
    assign ctrl_w = op_decode(op_w);
    assign wen_w  = ctrl_w.writes_rd && (rd_w != '0);

    assign rf_rs1_addr = rs1_w;
    assign rf_rs2_addr = rs2_w;

    // Gating with rst_n keeps fetch stalled while reset is held.
    assign if_ready    = rst_n && !flush && !hazard_w && (!ex_valid_q || ex_ready);
    assign accept_w    = if_valid && if_ready;
    assign flush_clr_w = flush && ex_valid_q && slot_q.wen;

    decode_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_i       (rs1_w),
        .rs2_i       (rs2_w),
        .rd_i        (rd_w),
        .use_rs1_i   (ctrl_w.use_rs1),
        .use_rs2_i   (ctrl_w.use_rs2),
        .wen_i       (wen_w),
        .accept_i    (accept_w),
        .wb_valid_i  (wb_valid),
        .wb_rd_i     (wb_rd),
        .flush_clr_i (flush_clr_w),
        .flush_rd_i  (slot_q.rd),
        .hazard_o    (hazard_w)
    );

    always_comb begin
        slot_d     = slot_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept_w) begin
            ex_valid_d     = 1'b1;
            slot_d.op      = op_w;
            slot_d.funct   = if_instr[FN_LSB +: FN_W];
            slot_d.rd      = rd_w;
            slot_d.wen     = wen_w;
            slot_d.illegal = ctrl_w.illegal;
            slot_d.rs1_val = operand_sel(ctrl_w.use_rs1, rs1_w, rf_rs1_data, wb_valid, wb_rd, wb_data);
            slot_d.rs2_val = operand_sel(ctrl_w.use_rs2, rs2_w, rf_rs2_data, wb_valid, wb_rd, wb_data);
            slot_d.imm     = {{(XLEN-IMM_W){if_instr[IMM_LSB+IMM_W-1]}}, if_instr[IMM_LSB +: IMM_W]};
            slot_d.pc      = if_pc;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            slot_q     <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            slot_q     <= slot_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_op      = slot_q.op;
    assign ex_funct   = slot_q.funct;
    assign ex_rd      = slot_q.rd;
    assign ex_wen     = slot_q.wen;
    assign ex_illegal = slot_q.illegal;
    assign ex_rs1_val = slot_q.rs1_val;
    assign ex_rs2_val = slot_q.rs2_val;
    assign ex_imm     = slot_q.imm;
    assign ex_pc      = slot_q.pc;

endmodule
`default_nettype wire
